// File: rtl/serial_bram_pkg.sv
// Shared definitions for the serial <-> BRAM bridge: lane indices, widths and FSM encoding.
// Used by both directions so the byte lane order stays identical.
package serial_bram_pkg;

  localparam int unsigned MASK_W = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = MASK_W * BYTE_W;

  localparam int unsigned LANE_0 = 0;  // word[7:0]
  localparam int unsigned LANE_1 = 1;
  localparam int unsigned LANE_2 = 2;
  localparam int unsigned LANE_3 = 3;  // word[31:24]

  typedef enum logic [1:0] {
    StIdle,
    StWaitByte,
    StWrite,
    StDone
  } rx_state_e;

endpackage

// File: rtl/byte_lane_picker.sv
// Selects the highest still-pending byte lane as a one-hot vector and flags whether it is
// the last pending lane.
module byte_lane_picker
  import serial_bram_pkg::*;
(
  input  logic [MASK_W-1:0] pending,
  output logic [MASK_W-1:0] lane_sel,
  output logic              last_byte
);

  always_comb begin
    lane_sel = '0;
    if (pending[LANE_3]) begin
      lane_sel[LANE_3] = 1'b1;
    end else if (pending[LANE_2]) begin
      lane_sel[LANE_2] = 1'b1;
    end else if (pending[LANE_1]) begin
      lane_sel[LANE_1] = 1'b1;
    end else if (pending[LANE_0]) begin
      lane_sel[LANE_0] = 1'b1;
    end
  end

  assign last_byte = (|pending) && ((pending & ~lane_sel) == '0);

endmodule

// File: rtl/serial_data_to_bram.sv
// Collects a byte-masked 32-bit word from a UART RX byte stream and issues one byte-enabled
// BRAM write. Optional inter-byte timeout abort enabled by defining SERIAL_RX_TIMEOUT_EN.
module serial_data_to_bram
  import serial_bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [MASK_W-1:0]     bytes_to_receive,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [BYTE_W-1:0]     uart_data_in,
  input  logic                  uart_data_valid,
  output logic [WORD_W-1:0]     bram_data_out,
  output logic [ADDR_WIDTH-1:0] bram_write_addr,
  output logic [MASK_W-1:0]     bram_we,
  output logic                  bram_write,
  output logic                  receive_complete,
  output logic                  busy,
  output logic                  receive_error
);

  rx_state_e             state_q, state_d;
  logic [MASK_W-1:0]     mask_q, mask_d;
  logic [MASK_W-1:0]     pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]     data_q, data_d;
  logic                  err_q, err_d;
  logic [MASK_W-1:0]     lane_sel;
  logic                  last_byte;
  logic                  timeout_hit;

  byte_lane_picker u_picker (
    .pending   (pending_q),
    .lane_sel  (lane_sel),
    .last_byte (last_byte)
  );

`ifdef SERIAL_RX_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter idles at zero outside WAIT_BYTE, so entering WAIT_BYTE starts from zero.
  always_comb begin
    cnt_d = '0;
    if (state_q == StWaitByte && !uart_data_valid) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (state_q == StWaitByte) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) begin
          mask_d    = bytes_to_receive;
          pending_d = bytes_to_receive;
          addr_d    = write_addr;
          data_d    = '0;
          state_d   = (|bytes_to_receive) ? StWaitByte : StDone;
        end
      end
      StWaitByte: begin
        if (uart_data_valid) begin
          for (int unsigned i = 0; i < MASK_W; i++) begin
            if (lane_sel[i]) begin
              data_d[i*BYTE_W +: BYTE_W] = uart_data_in;
            end
          end
          pending_d = pending_q & ~lane_sel;
          if (last_byte) begin
            state_d = StWrite;
          end
        end else if (timeout_hit) begin
          pending_d = '0;
          err_d     = 1'b1;
          state_d   = StIdle;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      pending_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign bram_write       = (state_q == StWrite);
  assign bram_we          = bram_write ? mask_q : '0;
  assign receive_complete = (state_q == StDone);
  assign busy             = (state_q != StIdle);
  assign receive_error    = err_q;
  assign bram_data_out    = data_q;
  assign bram_write_addr  = addr_q;

endmodule

// File: tb/tb_serial_data_to_bram.sv
// Directed self-checking bench for serial_data_to_bram; the timeout case runs only when
// SERIAL_RX_TIMEOUT_EN is defined.
module tb_serial_data_to_bram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  bytes_to_receive = '0;
  logic [31:0] write_addr = '0;
  logic [7:0]  uart_data_in = '0;
  logic        uart_data_valid = 1'b0;
  logic [31:0] bram_data_out;
  logic [31:0] bram_write_addr;
  logic [3:0]  bram_we;
  logic        bram_write;
  logic        receive_complete;
  logic        busy;
  logic        receive_error;

  int n_checks = 0;
  int n_fails  = 0;
  int write_cnt = 0;
  int complete_cnt = 0;
  int wc0;
  int cc0;

  serial_data_to_bram #(
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .bytes_to_receive (bytes_to_receive),
    .write_addr       (write_addr),
    .uart_data_in     (uart_data_in),
    .uart_data_valid  (uart_data_valid),
    .bram_data_out    (bram_data_out),
    .bram_write_addr  (bram_write_addr),
    .bram_we          (bram_we),
    .bram_write       (bram_write),
    .receive_complete (receive_complete),
    .busy             (busy),
    .receive_error    (receive_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_write) write_cnt <= write_cnt + 1;
    if (receive_complete) complete_cnt <= complete_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All tasks begin and end at a falling edge.
  task automatic start_xfer(input logic [3:0] mask, input logic [31:0] addr);
    enable = 1'b1;
    bytes_to_receive = mask;
    write_addr = addr;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    uart_data_in = b;
    uart_data_valid = 1'b1;
    @(negedge clk);
    uart_data_valid = 1'b0;
  endtask

  // Called in the cycle right after the last byte was accepted.
  task automatic expect_write(input string tag, input logic [3:0] we, input logic [31:0] data,
                              input logic [31:0] addr);
    check_eq({tag, "_write"}, 32'(bram_write), 32'd1);
    check_eq({tag, "_we"}, 32'(bram_we), 32'(we));
    check_eq({tag, "_data"}, bram_data_out, data);
    check_eq({tag, "_addr"}, bram_write_addr, addr);
    check_eq({tag, "_cmpl_early"}, 32'(receive_complete), 32'd0);
    @(negedge clk);
    check_eq({tag, "_cmpl"}, 32'(receive_complete), 32'd1);
    check_eq({tag, "_write_off"}, 32'(bram_write), 32'd0);
    check_eq({tag, "_we_off"}, 32'(bram_we), 32'd0);
    @(negedge clk);
    check_eq({tag, "_cmpl_off"}, 32'(receive_complete), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"}, bram_data_out, 32'd0);
    check_eq({tag, "_addr"}, bram_write_addr, 32'd0);
    check_eq({tag, "_we"}, 32'(bram_we), 32'd0);
    check_eq({tag, "_outs"}, {28'd0, bram_write, receive_complete, busy, receive_error}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: single low lane
    start_xfer(4'b0001, 32'd12345);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wc0 = write_cnt;
    send_byte(8'h28, 0);
    expect_write("t1", 4'b0001, 32'h0000_0028, 32'd12345);
    check_eq("t1_nwrites", 32'(write_cnt - wc0), 32'd1);

    // 2: outer lanes, high lane first
    wc0 = write_cnt;
    start_xfer(4'b1001, 32'd200);
    send_byte(8'h0A, 0);
    check_eq("t2_no_early_write", 32'(write_cnt - wc0), 32'd0);
    send_byte(8'h28, 3);
    expect_write("t2", 4'b1001, 32'h0A00_0028, 32'd200);
    check_eq("t2_nwrites", 32'(write_cnt - wc0), 32'd1);

    // 3: full word with gaps, re-enable mid-transfer ignored
    wc0 = write_cnt;
    start_xfer(4'b1111, 32'd300);
    send_byte(8'h0A, 0);
    send_byte(8'h14, 20);
    start_xfer(4'b0001, 32'd99);
    send_byte(8'h1E, 5);
    check_eq("t3_partial", bram_data_out, 32'h0A14_1E00);
    send_byte(8'h28, 1);
    expect_write("t3", 4'b1111, 32'h0A14_1E28, 32'd300);
    check_eq("t3_nwrites", 32'(write_cnt - wc0), 32'd1);

    // 4: strobes in IDLE are dropped; outputs hold; empty mask completes without a write
    wc0 = write_cnt;
    send_byte(8'h77, 0);
    send_byte(8'h66, 2);
    check_eq("t4_hold_data", bram_data_out, 32'h0A14_1E28);
    check_eq("t4_hold_addr", bram_write_addr, 32'd300);
    start_xfer(4'b0000, 32'd40);
    check_eq("t4_cmpl", 32'(receive_complete), 32'd1);
    check_eq("t4_no_write", 32'(bram_write), 32'd0);
    check_eq("t4_data_clr", bram_data_out, 32'd0);
    check_eq("t4_addr", bram_write_addr, 32'd40);
    @(negedge clk);
    check_eq("t4_cmpl_off", 32'(receive_complete), 32'd0);
    check_eq("t4_idle", 32'(busy), 32'd0);
    check_eq("t4_nwrites", 32'(write_cnt - wc0), 32'd0);

    // 4b: enable with a coincident byte starts the transfer but drops that byte
    enable = 1'b1;
    bytes_to_receive = 4'b0001;
    write_addr = 32'd3;
    uart_data_in = 8'hAA;
    uart_data_valid = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    uart_data_valid = 1'b0;
    check_eq("t4b_busy", 32'(busy), 32'd1);
    check_eq("t4b_dropped", bram_data_out, 32'd0);
    send_byte(8'h33, 1);
    expect_write("t4b", 4'b0001, 32'h0000_0033, 32'd3);

    // 5: reset mid-transfer aborts with no write, then a fresh transfer
    wc0 = write_cnt;
    start_xfer(4'b1110, 32'd77);
    send_byte(8'h11, 2);
    check_eq("t5_partial", bram_data_out, 32'h1100_0000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("t5_rst");
    repeat (5) @(negedge clk);
    check_eq("t5_no_write", 32'(write_cnt - wc0), 32'd0);
    start_xfer(4'b0100, 32'd8);
    send_byte(8'h55, 1);
    expect_write("t5", 4'b0100, 32'h0055_0000, 32'd8);

`ifdef SERIAL_RX_TIMEOUT_EN
    // 6: silence after one byte aborts after TIMEOUT_CYCLES clocks
    begin
      int n;
      wc0 = write_cnt;
      cc0 = complete_cnt;
      start_xfer(4'b0011, 32'd5);
      send_byte(8'h01, 0);
      n = 0;
      while (!receive_error && n < 200) begin
        @(negedge clk);
        n++;
      end
      check_eq("t6_timeout_clks", 32'(n), 32'd50);
      check_eq("t6_idle", 32'(busy), 32'd0);
      @(negedge clk);
      check_eq("t6_err_pulse", 32'(receive_error), 32'd0);
      check_eq("t6_no_write", 32'(write_cnt - wc0), 32'd0);
      check_eq("t6_no_cmpl", 32'(complete_cnt - cc0), 32'd0);
    end
`else
    check_eq("no_error", 32'(receive_error), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
